// File: rtl/risc_spm_pkg.sv
// Shared opcodes, FSM states and register-select codes for the SPM core.
// RISC_SPM_ILLEGAL_HALT_EN: when defined, opcodes 9-14 decode as HALT instead of NOP.
package risc_spm_pkg;

  localparam int DEFAULT_WORD_SIZE = 8;
  localparam int DEFAULT_MEM_DEPTH = 256;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_RD   = 4'd5;
  localparam logic [3:0] OP_WR   = 4'd6;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_BRZ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] REG_R0 = 2'd0;
  localparam logic [1:0] REG_R1 = 2'd1;
  localparam logic [1:0] REG_R2 = 2'd2;
  localparam logic [1:0] REG_R3 = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_t;

  // Folds the unused opcode space onto NOP or HALT so the decoder sees only legal codes.
  function automatic logic [3:0] decode_op(input logic [3:0] op);
    logic [3:0] res;
    res = op;
    if (op >= 4'd9 && op <= 4'd14) begin
`ifdef RISC_SPM_ILLEGAL_HALT_EN
      res = OP_HALT;
`else
      res = OP_NOP;
`endif
    end
    return res;
  endfunction

endpackage

// File: rtl/risc_spm_sram.sv
// Single-port program/data memory: combinational read, write on the rising clock edge.
// No reset on the array; contents are preloaded and inspected hierarchically.
module risc_spm_sram #(
  parameter int WORD_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] o_rdata
);

  logic [WORD_SIZE-1:0] memory [0:MEM_DEPTH-1];

  assign o_rdata = memory[i_addr];

  always @(posedge clk) begin
    if (i_we) memory[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/risc_spm_core.sv
// 8-bit stored-program CPU: four registers, zero flag, embedded 256x8 memory (M2_SRAM).
// RISC_SPM_ILLEGAL_HALT_EN selects HALT (defined) or NOP (undefined) for opcodes 9-14.
//
// state  | meaning
// IDLE   | held in reset / first cycle after release
// FET1   | Add_R <= PC
// FET2   | IR <= mem[Add_R], PC++
// DEC    | decode; single-cycle ops finish here
// EX1    | ADD/SUB/AND writeback and Z
// RD1/2  | fetch operand address, then dest <= mem
// WR1/2  | fetch operand address, then mem <= src
// BR1/2  | fetch pointer address, then PC <= mem
// HALT   | frozen until reset
module risc_spm_core
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input logic clk,
  input logic rst
);

  state_t r_state, w_state_nxt;
  logic [WORD_SIZE-1:0] R0, R1, R2, R3, PC, IR, Add_R, Reg_Y;
  logic                 Z;

  logic [WORD_SIZE-1:0] w_pc_nxt, w_ir_nxt, w_addr_nxt, w_y_nxt;
  logic [WORD_SIZE-1:0] w_src, w_dest, w_alu, w_dest_data, w_mem_rdata;
  logic                 w_z_nxt, w_dest_we, w_mem_we;
  logic [3:0]           w_op;

  assign w_op = decode_op(IR[7:4]);

  risc_spm_sram #(.WORD_SIZE(WORD_SIZE), .MEM_DEPTH(MEM_DEPTH)) M2_SRAM (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (Add_R),
    .i_wdata (w_src),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    case (IR[3:2])
      REG_R0:  w_src = R0;
      REG_R1:  w_src = R1;
      REG_R2:  w_src = R2;
      default: w_src = R3;
    endcase
    case (IR[1:0])
      REG_R0:  w_dest = R0;
      REG_R1:  w_dest = R1;
      REG_R2:  w_dest = R2;
      default: w_dest = R3;
    endcase
    case (w_op)
      OP_ADD:  w_alu = w_dest + Reg_Y;
      OP_SUB:  w_alu = w_dest - Reg_Y;
      default: w_alu = w_dest & Reg_Y;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = PC;
    w_ir_nxt    = IR;
    w_addr_nxt  = Add_R;
    w_y_nxt     = Reg_Y;
    w_z_nxt     = Z;
    w_dest_we   = 1'b0;
    w_dest_data = '0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FET1;
      S_FET1: begin
        w_addr_nxt  = PC;
        w_state_nxt = S_FET2;
      end
      S_FET2: begin
        w_ir_nxt    = w_mem_rdata;
        w_pc_nxt    = PC + WORD_SIZE'(1);
        w_state_nxt = S_DEC;
      end
      S_DEC: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND: begin
            w_y_nxt     = w_src;
            w_state_nxt = S_EX1;
          end
          OP_NOT: begin
            w_dest_we   = 1'b1;
            w_dest_data = ~w_src;
            w_z_nxt     = (~w_src == '0);
            w_state_nxt = S_FET1;
          end
          OP_RD: begin
            w_addr_nxt  = PC;
            w_state_nxt = S_RD1;
          end
          OP_WR: begin
            w_addr_nxt  = PC;
            w_state_nxt = S_WR1;
          end
          OP_BR: begin
            w_addr_nxt  = PC;
            w_state_nxt = S_BR1;
          end
          OP_BRZ: begin
            if (Z) begin
              w_addr_nxt  = PC;
              w_state_nxt = S_BR1;
            end else begin
              w_pc_nxt    = PC + WORD_SIZE'(1);
              w_state_nxt = S_FET1;
            end
          end
          OP_HALT: w_state_nxt = S_HALT;
          default: w_state_nxt = S_FET1;
        endcase
      end
      S_EX1: begin
        w_dest_we   = 1'b1;
        w_dest_data = w_alu;
        w_z_nxt     = (w_alu == '0);
        w_state_nxt = S_FET1;
      end
      S_RD1, S_WR1: begin
        w_addr_nxt  = w_mem_rdata;
        w_pc_nxt    = PC + WORD_SIZE'(1);
        w_state_nxt = (r_state == S_RD1) ? S_RD2 : S_WR2;
      end
      S_BR1: begin
        w_addr_nxt  = w_mem_rdata;
        w_state_nxt = S_BR2;
      end
      S_RD2: begin
        w_dest_we   = 1'b1;
        w_dest_data = w_mem_rdata;
        w_state_nxt = S_FET1;
      end
      S_WR2: begin
        w_mem_we    = 1'b1;
        w_state_nxt = S_FET1;
      end
      S_BR2: begin
        w_pc_nxt    = w_mem_rdata;
        w_state_nxt = S_FET1;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      PC      <= '0;
      IR      <= '0;
      Add_R   <= '0;
      Reg_Y   <= '0;
      Z       <= 1'b0;
      R0      <= '0;
      R1      <= '0;
      R2      <= '0;
      R3      <= '0;
    end else begin
      r_state <= w_state_nxt;
      PC      <= w_pc_nxt;
      IR      <= w_ir_nxt;
      Add_R   <= w_addr_nxt;
      Reg_Y   <= w_y_nxt;
      Z       <= w_z_nxt;
      if (w_dest_we) begin
        case (IR[1:0])
          REG_R0:  R0 <= w_dest_data;
          REG_R1:  R1 <= w_dest_data;
          REG_R2:  R2 <= w_dest_data;
          default: R3 <= w_dest_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risc_spm_core.sv
// Directed and randomized program checks for risc_spm_core against an
// instruction-level reference interpreter.
module tb_risc_spm_core;
  import risc_spm_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] img   [256];
  logic [7:0] m_mem [256];
  logic [7:0] m_r   [4];
  logic [7:0] m_pc;
  logic       m_z;
  int         m_cyc;
  bit         m_halted;

  risc_spm_core #(.WORD_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level interpreter; m_cyc counts clock edges from reset release to HALT.
  task automatic model_run(input int max_instr);
    logic [7:0] ins, a;
    logic [3:0] op;
    int s, d;
    m_mem = img;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_z = 1'b0; m_cyc = 1; m_halted = 1'b0;
    for (int n = 0; n < max_instr && !m_halted; n++) begin
      ins = m_mem[m_pc]; m_pc++;
      op = ins[7:4]; s = int'(ins[3:2]); d = int'(ins[1:0]);
      if (op >= 4'd9 && op <= 4'd14) begin
`ifdef RISC_SPM_ILLEGAL_HALT_EN
        op = 4'd15;
`else
        op = 4'd0;
`endif
      end
      case (op)
        4'd1: begin m_r[d] = m_r[d] + m_r[s]; m_z = (m_r[d] == 8'h00); m_cyc += 4; end
        4'd2: begin m_r[d] = m_r[d] - m_r[s]; m_z = (m_r[d] == 8'h00); m_cyc += 4; end
        4'd3: begin m_r[d] = m_r[d] & m_r[s]; m_z = (m_r[d] == 8'h00); m_cyc += 4; end
        4'd4: begin m_r[d] = ~m_r[s]; m_z = (m_r[d] == 8'h00); m_cyc += 3; end
        4'd5: begin a = m_mem[m_pc]; m_pc++; m_r[d] = m_mem[a]; m_cyc += 5; end
        4'd6: begin a = m_mem[m_pc]; m_pc++; m_mem[a] = m_r[s]; m_cyc += 5; end
        4'd7: begin a = m_mem[m_pc]; m_pc = m_mem[a]; m_cyc += 5; end
        4'd8: begin
          if (m_z) begin a = m_mem[m_pc]; m_pc = m_mem[a]; m_cyc += 5; end
          else begin m_pc++; m_cyc += 3; end
        end
        4'd15: begin m_cyc += 3; m_halted = 1'b1; end
        default: m_cyc += 3;
      endcase
    end
  endtask

  task automatic hold_reset_and_load();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.M2_SRAM.memory[i] = img[i];
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input int max_edges, output int edges);
    edges = 0;
    while (dut.r_state !== S_HALT && edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("halt_reached", 32'(dut.r_state === S_HALT), 32'd1);
  endtask

  task automatic check_against_model(input string pfx);
    int diffs;
    diffs = 0;
    chk({pfx, "_R0"}, dut.R0, m_r[0]);
    chk({pfx, "_R1"}, dut.R1, m_r[1]);
    chk({pfx, "_R2"}, dut.R2, m_r[2]);
    chk({pfx, "_R3"}, dut.R3, m_r[3]);
    chk({pfx, "_Z"},  dut.Z,  m_z);
    chk({pfx, "_PC"}, dut.PC, m_pc);
    for (int i = 0; i < 256; i++)
      if (dut.M2_SRAM.memory[i] !== m_mem[i]) diffs++;
    chk({pfx, "_mem_diffs"}, diffs, 0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  initial begin
    int e, total, pc, nb, k;
    logic [1:0] s, d;
    rst = 1'b0;

    // Reset state and countdown loop
    clear_img();
    img[0] = 8'h52; img[1] = 8'd130; img[2] = 8'h53; img[3] = 8'd131;
    img[4] = 8'h51; img[5] = 8'd128; img[6] = 8'h50; img[7] = 8'd129;
    img[8] = 8'h00;
    img[9] = 8'h21; img[10] = 8'h80; img[11] = 8'd134;
    img[12] = 8'h1B; img[13] = 8'h70; img[14] = 8'd140;
    img[128] = 8'd6; img[129] = 8'd1; img[130] = 8'd2; img[131] = 8'd0;
    img[134] = 8'd139; img[139] = 8'hF0; img[140] = 8'd9;
    hold_reset_and_load();
    chk("rst_PC", dut.PC, 0);
    chk("rst_IR", dut.IR, 0);
    chk("rst_AddR", dut.Add_R, 0);
    chk("rst_RegY", dut.Reg_Y, 0);
    chk("rst_R0", dut.R0, 0);
    chk("rst_R1", dut.R1, 0);
    chk("rst_R2", dut.R2, 0);
    chk("rst_R3", dut.R3, 0);
    chk("rst_Z", dut.Z, 0);
    chk("rst_state", dut.r_state, S_IDLE);
    release_reset();
    step(1);
    chk("first_fet1", dut.r_state, S_FET1);
    step(1);
    chk("fet1_addr", dut.Add_R, 0);
    chk("fet2_state", dut.r_state, S_FET2);
    run_to_halt(3000, e);
    total = 2 + e;
    model_run(1000);
    chk("loop_cycles", total, m_cyc);
    chk("loop_R1", dut.R1, 8'd0);
    chk("loop_R3", dut.R3, 8'd10);
    chk("loop_Z", dut.Z, 1);
    chk("loop_PC", dut.PC, 8'd140);
    check_against_model("loop");
    step(4);
    chk("halt_pc_frozen", dut.PC, 8'd140);

    // Write timing
    clear_img();
    img[0] = 8'h52; img[1] = 8'd130; img[2] = 8'h68; img[3] = 8'd135; img[4] = 8'hF0;
    img[130] = 8'd2; img[135] = 8'h55;
    hold_reset_and_load();
    release_reset();
    step(10);
    chk("wr_wr2_state", dut.r_state, S_WR2);
    chk("wr_before", dut.M2_SRAM.memory[135], 8'h55);
    step(1);
    chk("wr_after", dut.M2_SRAM.memory[135], 8'd2);
    chk("wr_back_fet1", dut.r_state, S_FET1);
    run_to_halt(200, e);
    model_run(100);
    chk("wr_cycles", 11 + e, m_cyc);
    check_against_model("wr");

    // Reset asserted during WR1
    hold_reset_and_load();
    release_reset();
    step(9);
    chk("mid_wr1_state", dut.r_state, S_WR1);
    rst = 1'b0;
    #1;
    chk("mid_state", dut.r_state, S_IDLE);
    chk("mid_R2", dut.R2, 0);
    chk("mid_PC", dut.PC, 0);
    chk("mid_AddR", dut.Add_R, 0);
    chk("mid_IR", dut.IR, 0);
    step(3);
    chk("mid_no_write", dut.M2_SRAM.memory[135], 8'h55);

    // Flags
    clear_img();
    img[0] = 8'h50; img[1] = 8'd100; img[2] = 8'h41; img[3] = 8'h31;
    img[4] = 8'h52; img[5] = 8'd100; img[6] = 8'hF0; img[100] = 8'h0F;
    hold_reset_and_load();
    release_reset();
    step(9);
    chk("not_R1", dut.R1, 8'hF0);
    chk("not_Z", dut.Z, 0);
    step(4);
    chk("and_R1", dut.R1, 8'h00);
    chk("and_Z", dut.Z, 1);
    step(5);
    chk("rd_R2", dut.R2, 8'h0F);
    chk("rd_keeps_Z", dut.Z, 1);
    run_to_halt(100, e);
    model_run(100);
    chk("flags_cycles", 18 + e, m_cyc);
    check_against_model("flags");

    // BRZ not taken
    clear_img();
    img[10] = 8'h80; img[11] = 8'd200; img[12] = 8'hF0; img[200] = 8'd50; img[50] = 8'hF0;
    hold_reset_and_load();
    release_reset();
    step(31);
    chk("brz_at_fet1", dut.r_state, S_FET1);
    chk("brz_pc10", dut.PC, 8'd10);
    step(3);
    chk("brz_nt_state", dut.r_state, S_FET1);
    chk("brz_nt_pc", dut.PC, 8'd12);
    step(1);
    chk("brz_nt_fetch", dut.Add_R, 8'd12);
    run_to_halt(100, e);
    model_run(100);
    chk("brz_cycles", 35 + e, m_cyc);
    check_against_model("brz");

    // Illegal opcode
    clear_img();
    img[0] = 8'h9A; img[1] = 8'hF0;
    hold_reset_and_load();
    release_reset();
    run_to_halt(100, e);
    model_run(100);
    chk("ill_cycles", e, m_cyc);
`ifdef RISC_SPM_ILLEGAL_HALT_EN
    chk("ill_PC", dut.PC, 8'd1);
`else
    chk("ill_PC", dut.PC, 8'd2);
`endif
    check_against_model("ill");

    // Randomized straight-line programs with self-targeting branches
    for (int iter = 0; iter < 20; iter++) begin
      clear_img();
      for (int a = 200; a < 216; a++) img[a] = 8'($urandom);
      pc = 0; nb = 0;
      while (pc < 90) begin
        k = int'($urandom_range(0, 11));
        s = 2'($urandom_range(0, 3));
        d = 2'($urandom_range(0, 3));
        case (k)
          1, 2: begin img[pc] = {4'd1, s, d}; pc += 1; end
          3:    begin img[pc] = {4'd2, s, d}; pc += 1; end
          4:    begin img[pc] = {4'd3, s, d}; pc += 1; end
          5:    begin img[pc] = {4'd4, s, d}; pc += 1; end
          6, 7: begin img[pc] = {4'd5, s, d}; img[pc+1] = 8'(200 + $urandom_range(0, 15)); pc += 2; end
          8:    begin img[pc] = {4'd6, s, d}; img[pc+1] = 8'(200 + $urandom_range(0, 15)); pc += 2; end
          9, 10: begin
            if (nb < 20) begin
              img[pc] = {(k == 9) ? 4'd8 : 4'd7, s, d};
              img[pc+1] = 8'(230 + nb);
              img[230 + nb] = 8'(pc + 2);
              nb++; pc += 2;
            end else begin
              img[pc] = {4'd0, s, d}; pc += 1;
            end
          end
          11: begin
            if ($urandom_range(0, 3) == 0) img[pc] = {4'($urandom_range(9, 14)), s, d};
            else img[pc] = {4'd0, s, d};
            pc += 1;
          end
          default: begin img[pc] = {4'd0, s, d}; pc += 1; end
        endcase
      end
      img[pc] = 8'hF0;
      hold_reset_and_load();
      release_reset();
      run_to_halt(3000, e);
      model_run(500);
      chk("rnd_cycles", e, m_cyc);
      check_against_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
